axi_const_bank: RTL and testbench
=================================

AXI_CONST_BANK -- requirements
Module: axi_const_bank

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, read/write address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (32 or 64 only).
REQ-003 SHALL have parameter NUM_REGS, default 8, number of constant words (1..64).
REQ-004 SHALL have parameter CONST_VALUES, default all words 32'hDEADBEEF, flat NUM_REGS*C_S_AXI_DATA_WIDTH vector, word i at bits [i*DW +: DW].
REQ-005 SHALL have port S_AXI_ACLK  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port S_AXI_ARESET  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH: read address channel.
REQ-008 SHALL have ports S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RDATA out C_S_AXI_DATA_WIDTH, S_AXI_RRESP out 2: read data channel.
REQ-009 SHALL have, only with AXI_CONST_WRITE_EN, ports S_AXI_AWVALID/AWREADY/AWADDR, S_AXI_WVALID/WREADY/WDATA/WSTRB, S_AXI_BVALID/BREADY/BRESP (AXI4-Lite widths).

Function
REQ-010 SHALL decode word index = ARADDR[ADDR_LSB +: 7], ADDR_LSB = log2(DW/8); upper address bits and low byte-offset bits ignored.
REQ-011 SHALL map index 0..NUM_REGS-1 to CONST_VALUES words, RRESP OKAY (2'b00).
REQ-012 SHALL map index NUM_REGS to ID word: {16'hC0B5, 16-bit NUM_REGS}, zero-extended to DW, OKAY.
REQ-013 SHALL map index NUM_REGS+1 to read-count register, OKAY.
REQ-014 SHALL return RDATA=0, RRESP=SLVERR (2'b10) for any other index.
REQ-015 SHALL implement two states: IDLE (no response held) and RESP (RVALID=1).
REQ-016 SHALL, on AR handshake (ARVALID&&ARREADY) in cycle N, assert RVALID with registered RDATA/RRESP in cycle N+1.
REQ-017 SHALL drive ARREADY = !RVALID || RREADY (combinational), giving back-to-back throughput of one read per cycle.
REQ-018 SHALL hold RDATA/RRESP/RVALID stable while RVALID && !RREADY.
REQ-019 SHALL return RVALID to 0 (state IDLE) after R handshake when no new AR handshake occurs in the same cycle; SHALL stay in RESP with new data when one does.
REQ-020 SHALL increment read-count on every R handshake (OKAY or SLVERR), wrapping 2^DW-1 -> 0.
REQ-021 SHALL return for a read of the read-count register the value sampled at its AR handshake, excluding that read itself.

Reset
REQ-022 SHALL, while S_AXI_ARESET=1 at a clock edge, set RVALID=0, RDATA=0, RRESP=00, read-count=0, state IDLE; ARREADY reads 1 during reset.
REQ-023 SHALL discard an outstanding response on reset mid-transaction; no RVALID after reset release until a new AR handshake.

Configuration
REQ-024 SHALL, with macro AXI_CONST_WRITE_EN defined, include the write-channel ports; writes accepted once both AW and W are valid (AWREADY=WREADY=1 in that cycle), data discarded, BVALID next cycle with BRESP=SLVERR, held until BREADY; one write outstanding max.
REQ-025 SHALL, without AXI_CONST_WRITE_EN, have no write ports and no write logic; read behaviour identical in both builds.

Structure
REQ-026 SHALL place RESP_OKAY, RESP_SLVERR, ID_MAGIC (16'hC0B5) and the IDLE/RESP state encoding in shared package axi_const_pkg.
REQ-027 SHALL implement the write responder as sub-module axi_const_wr_sink, instantiated only under AXI_CONST_WRITE_EN.

Verification
REQ-028 SHALL cover: NUM_REGS=4, CONST_VALUES={4,3,2,1}, read 0x8 -> RDATA=3, OKAY, RVALID one cycle after AR handshake.
REQ-029 SHALL cover: RREADY=0 for 5 cycles on a pending read -> RVALID, RDATA, RRESP unchanged, ARREADY=0 throughout.
REQ-030 SHALL cover: 3 back-to-back ARs with RREADY=1 -> 3 responses in 3 consecutive cycles, read-count then = 3.
REQ-031 SHALL cover: read 0x18 with NUM_REGS=4 (index 6) -> RDATA=0, RRESP=2'b10; read 0x10 -> 32'hC0B50004.
REQ-032 SHALL cover: reset asserted while RVALID=1 and RREADY=0 -> RVALID=0 next cycle, read-count=0, no stale response after release.
REQ-033 SHALL cover (AXI_CONST_WRITE_EN): AW and W valid together -> BVALID next cycle, BRESP=2'b10, subsequent read of index 0 unchanged.

Source files
------------

// File: rtl/axi_const_pkg.sv
// Shared definitions for the AXI4-Lite constant bank: response codes, ID magic
// number and the read-side FSM encoding.
package axi_const_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] ID_MAGIC    = 16'hC0B5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/axi_const_wr_sink.sv
// Write responder: swallows every AXI4-Lite write and answers SLVERR.
// Only built into axi_const_bank when AXI_CONST_WRITE_EN is defined.
module axi_const_wr_sink
    import axi_const_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       awvalid,
    input  logic       wvalid,
    input  logic       bready,
    output logic       awready,
    output logic       wready,
    output logic       bvalid,
    output logic [1:0] bresp
);

    logic accept;

    // AW and W are taken together, and only while no B response is pending.
    assign accept  = awvalid && wvalid && !bvalid;
    assign awready = accept;
    assign wready  = accept;
    assign bresp   = RESP_SLVERR;

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid <= 1'b0;
        end else if (accept) begin
            bvalid <= 1'b1;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_const_bank.sv
// AXI4-Lite read-only bank of constant words, an ID word and a read counter.
// Define AXI_CONST_WRITE_EN to add write channels that answer every write with SLVERR.
module axi_const_bank
    import axi_const_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 8,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] CONST_VALUES =
        {NUM_REGS{C_S_AXI_DATA_WIDTH'(32'hDEADBEEF)}}
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          fsm_state
`ifdef AXI_CONST_WRITE_EN
    ,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    output logic [1:0]                      S_AXI_BRESP
`endif
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = $clog2(DW / 8);

    state_t          state;
    logic [DW-1:0]   rd_cnt;
    logic [DW-1:0]   cnt_sample;
    logic [6:0]      idx;
    logic [DW-1:0]   lk_data;
    logic [1:0]      lk_resp;
    logic            ar_hs;
    logic            r_hs;
    logic            unused_bits;

    assign S_AXI_RVALID  = (state == ST_RESP);
    assign S_AXI_ARREADY = !S_AXI_RVALID || S_AXI_RREADY;
    assign fsm_state     = state;

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;
    assign idx   = S_AXI_ARADDR[ADDR_LSB +: 7];

    // A read completing in the same cycle as this request is already counted.
    assign cnt_sample = rd_cnt + DW'(r_hs);

    always_comb begin
        lk_data = '0;
        lk_resp = RESP_SLVERR;
        if (int'(idx) < NUM_REGS) begin
            lk_resp = RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(idx) == i) begin
                    lk_data = CONST_VALUES[i*DW +: DW];
                end
            end
        end else if (int'(idx) == NUM_REGS) begin
            lk_data = DW'({ID_MAGIC, 16'(NUM_REGS)});
            lk_resp = RESP_OKAY;
        end else if (int'(idx) == NUM_REGS + 1) begin
            lk_data = cnt_sample;
            lk_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state       <= ST_IDLE;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
            rd_cnt      <= '0;
        end else begin
            if (r_hs) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            // A new request in the same cycle as an R handshake keeps the FSM in RESP.
            if (ar_hs) begin
                state       <= ST_RESP;
                S_AXI_RDATA <= lk_data;
                S_AXI_RRESP <= lk_resp;
            end else if (r_hs) begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef AXI_CONST_WRITE_EN
    axi_const_wr_sink u_wr_sink (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .awvalid (S_AXI_AWVALID),
        .wvalid  (S_AXI_WVALID),
        .bready  (S_AXI_BREADY),
        .awready (S_AXI_AWREADY),
        .wready  (S_AXI_WREADY),
        .bvalid  (S_AXI_BVALID),
        .bresp   (S_AXI_BRESP)
    );

    // Write address and data are deliberately discarded.
    assign unused_bits = ^{S_AXI_ARADDR, S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB};
`else
    assign unused_bits = ^S_AXI_ARADDR;
`endif

endmodule

// File: tb/tb_axi_const_bank.sv
// Directed bench for axi_const_bank with NUM_REGS=4 and words {4,3,2,1}.
// Write-channel scenario is compiled in when AXI_CONST_WRITE_EN is defined.
module tb_axi_const_bank;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          fsm_state;
`ifdef AXI_CONST_WRITE_EN
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    axi_const_bank #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .NUM_REGS           (4),
        .CONST_VALUES       (128'h00000004_00000003_00000002_00000001)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .fsm_state     (fsm_state)
`ifdef AXI_CONST_WRITE_EN
        ,
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_BRESP   (bresp)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: one complete read with RREADY high; returns the captured response.
    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output logic valid);
        int n;
        n = 0;
        rready  = 1'b1;
        arvalid = 1'b1;
        araddr  = addr;
        while (!arready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin
            fails++;
            $display("FAIL read_timeout: arready stayed %b, required 1 (addr %h)", arready, addr);
        end
        step();
        arvalid = 1'b0;
        data  = rdata;
        resp  = rresp;
        valid = rvalid;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b, required 0", rvalid); end
        checks++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
        checks++;
        if (rresp !== 2'b00) begin fails++; $display("FAIL reset_rresp: got %b, required 00", rresp); end
        checks++;
        if (arready !== 1'b1) begin fails++; $display("FAIL reset_arready: got %b, required 1", arready); end
        checks++;
        if (fsm_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %b, required 0", fsm_state); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_stall();
        arvalid = 1'b1;
        araddr  = 32'h8;
        rready  = 1'b0;
        step();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin fails++; $display("FAIL first_rvalid: got %b, required 1", rvalid); end
        checks++;
        if (rdata !== 32'd3) begin fails++; $display("FAIL first_rdata: got %h, required 3", rdata); end
        checks++;
        if (rresp !== 2'b00) begin fails++; $display("FAIL first_rresp: got %b, required 00", rresp); end
        araddr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            arvalid = 1'b1;
            step();
            checks++;
            if ({rvalid, rdata, rresp, arready} !== {1'b1, 32'd3, 2'b00, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h r=%b ar=%b, required v=1 d=3 r=00 ar=0",
                         i, rvalid, rdata, rresp, arready);
            end
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        step();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin fails++; $display("FAIL stall_release: rvalid %b, required 0", rvalid); end
    endtask

    task automatic test_decode();
        logic [AW-1:0] addrs [10];
        logic [DW-1:0] exp_d [10];
        logic [1:0]    exp_r [10];
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        addrs = '{32'h0, 32'h4, 32'hC, 32'h10, 32'h18, 32'h1C, 32'h1000_0008, 32'hB, 32'h14, 32'h14};
        exp_d = '{32'd1, 32'd2, 32'd4, 32'hC0B5_0004, 32'h0, 32'h0, 32'd3, 32'd3, 32'd9, 32'd10};
        exp_r = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 10; i++) begin
            do_read(addrs[i], d, r, v);
            checks++;
            if ({v, d, r} !== {1'b1, exp_d[i], exp_r[i]}) begin
                fails++;
                $display("FAIL decode[%h]: got v=%b d=%h r=%b, required v=1 d=%h r=%b",
                         addrs[i], v, d, r, exp_d[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [3];
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        exp_d = '{32'd1, 32'd2, 32'd3};
        rst = 1'b1;
        step();
        rst = 1'b0;
        rready  = 1'b1;
        arvalid = 1'b1;
        araddr  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            araddr = 32'(4 * (i + 1));
            if (i == 2) arvalid = 1'b0;
            checks++;
            if ({rvalid, rdata, arready} !== {1'b1, exp_d[i], 1'b1}) begin
                fails++;
                $display("FAIL b2b[%0d]: got v=%b d=%h ar=%b, required v=1 d=%h ar=1",
                         i, rvalid, rdata, arready, exp_d[i]);
            end
        end
        step();
        rready = 1'b0;
        checks++;
        if ({rvalid, fsm_state} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_idle: got v=%b st=%b, required 0 0", rvalid, fsm_state);
        end
        do_read(32'h14, d, r, v);
        checks++;
        if (d !== 32'd3) begin fails++; $display("FAIL b2b_count: got %0d, required 3", d); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        arvalid = 1'b1;
        araddr  = 32'h8;
        rready  = 1'b0;
        step();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin fails++; $display("FAIL mid_pending: rvalid %b, required 1", rvalid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({rvalid, rdata, rresp, fsm_state, arready} !== {1'b0, 32'h0, 2'b00, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset: got v=%b d=%h r=%b st=%b ar=%b, required v=0 d=0 r=00 st=0 ar=1",
                     rvalid, rdata, rresp, fsm_state, arready);
        end
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rvalid !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d]: rvalid %b, required 0", i, rvalid); end
        end
        rready = 1'b0;
        do_read(32'h14, d, r, v);
        checks++;
        if (d !== 32'd0) begin fails++; $display("FAIL mid_count: got %0d, required 0", d); end
    endtask

`ifdef AXI_CONST_WRITE_EN
    task automatic test_write();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        awvalid = 1'b1;
        awaddr  = 32'h0;
        wvalid  = 1'b0;
        step();
        checks++;
        if ({awready, wready, bvalid} !== 3'b000) begin
            fails++;
            $display("FAIL wr_aw_only: got aw=%b w=%b b=%b, required 000", awready, wready, bvalid);
        end
        wvalid = 1'b1;
        wdata  = 32'hFFFF_FFFF;
        wstrb  = 4'hF;
        #1;
        checks++;
        if ({awready, wready} !== 2'b11) begin
            fails++;
            $display("FAIL wr_accept: got aw=%b w=%b, required 11", awready, wready);
        end
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bvalid, bresp} !== 3'b110) begin
                fails++;
                $display("FAIL wr_bresp[%0d]: got b=%b r=%b, required b=1 r=10", i, bvalid, bresp);
            end
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin fails++; $display("FAIL wr_bclear: bvalid %b, required 0", bvalid); end
        do_read(32'h0, d, r, v);
        checks++;
        if ({d, r} !== {32'd1, 2'b00}) begin
            fails++;
            $display("FAIL wr_readback: got d=%h r=%b, required d=1 r=00", d, r);
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b0;
`ifdef AXI_CONST_WRITE_EN
        awvalid = 1'b0;
        awaddr  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b0;
`endif
        #1;
        test_reset();
        test_read_stall();
        test_decode();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_CONST_WRITE_EN
        test_write();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
